// File: rtl/id_stage_param.sv
// ============================================================================
// id_stage_param : IF/ID register, register file, decode, load-use hazard, ID/EX
// Revision: 1.0
// ============================================================================
`default_nettype none

module id_stage_param #(
   parameter int         DATA_W   = 16,
   parameter int         NUM_REGS = 8,
   parameter bit         BR_SEXT  = 1'b0,
   parameter logic [4:0] OP_NOP   = 5'b00000,
   parameter logic [4:0] OP_HALT  = 5'b00001,
   parameter logic [4:0] OP_LOAD  = 5'b00010,
   parameter logic [4:0] OP_STORE = 5'b00011,
   parameter logic [4:0] OP_BZ    = 5'b01100,
   parameter logic [4:0] OP_BN    = 5'b01101
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_valid,
   input  logic [15:0]       if_instr,
   input  logic              flush,
   input  logic              wb_we,
   input  logic [2:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              stall,
   output logic              ex_valid,
   output logic [4:0]        ex_opcode,
   output logic [2:0]        ex_dest,
   output logic              ex_reg_we,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [DATA_W-1:0] ex_smdr,
   output logic [3:0]        ex_val2,
   output logic [3:0]        ex_val3,
   output logic              halted
);

   logic [15:0]       id_ir_q, id_ir_d;
   logic              id_valid_q, id_valid_d;
   logic [DATA_W-1:0] gr_q [NUM_REGS];

   logic              ex_valid_q;
   logic [4:0]        ex_opcode_q;
   logic [2:0]        ex_dest_q;
   logic              ex_reg_we_q;
   logic [DATA_W-1:0] ex_a_q, ex_b_q, ex_smdr_q;
   logic [3:0]        ex_val2_q, ex_val3_q;
   logic              halted_q;

   logic [4:0]        opcode;
   logic [2:0]        r1, r2, r3;
   logic              is_br, is_ld, is_st, is_nh;
   logic              use_r1, use_r2, use_r3, hazard, issue;
   logic              reg_we;
   logic [DATA_W-1:0] op_a, op_b, smdr;

   // Register read with write-through bypass from the writeback port
   function automatic logic [DATA_W-1:0] rd(input logic [2:0] addr);
      logic [DATA_W-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (addr == 3'(i)) v = gr_q[i];
      end
      if (wb_we && (wb_addr == addr)) v = wb_data;
      return v;
   endfunction

   always_comb begin
      opcode = id_ir_q[15:11];
      r1     = id_ir_q[10:8];
      r2     = id_ir_q[6:4];
      r3     = id_ir_q[2:0];
      is_br  = (opcode == OP_BZ) || (opcode == OP_BN);
      is_ld  = (opcode == OP_LOAD);
      is_st  = (opcode == OP_STORE);
      is_nh  = (opcode == OP_NOP) || (opcode == OP_HALT);
      reg_we = !(is_nh || is_st || is_br);

      use_r1 = is_br || is_st;
      use_r2 = !is_br && !is_nh;
      use_r3 = !is_br && !is_nh && !is_st && !is_ld;

      op_a = is_br ? rd(r1) : rd(r2);
      if (is_ld || is_st) begin
         op_b = {{(DATA_W-4){1'b0}}, id_ir_q[3:0]};
      end else if (is_br) begin
         op_b = BR_SEXT ? {{(DATA_W-8){id_ir_q[7]}}, id_ir_q[7:0]}
                        : {{(DATA_W-8){1'b0}}, id_ir_q[7:0]};
      end else begin
         op_b = rd(r3);
      end
      smdr = is_st ? rd(r1) : '0;

      hazard = ex_valid_q && (ex_opcode_q == OP_LOAD) &&
               ((use_r1 && (ex_dest_q == r1)) ||
                (use_r2 && (ex_dest_q == r2)) ||
                (use_r3 && (ex_dest_q == r3)));
      stall  = id_valid_q && hazard && !flush;
      issue  = id_valid_q && !flush && !stall && !halted_q;

      id_ir_d    = id_ir_q;
      id_valid_d = id_valid_q;
      if (flush) begin
         id_ir_d    = 16'h0000;
         id_valid_d = 1'b0;
      end else if (!stall && !halted_q) begin
         id_ir_d    = if_instr;
         id_valid_d = if_valid;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         id_ir_q    <= 16'h0000;
         id_valid_q <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) gr_q[i] <= '0;
      end else begin
         id_ir_q    <= id_ir_d;
         id_valid_q <= id_valid_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wb_we && (wb_addr == 3'(i))) gr_q[i] <= wb_data;
         end
      end
   end

   // Anything not issued becomes an all-zero bubble on the ID/EX register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ex_valid_q  <= 1'b0;
         ex_opcode_q <= OP_NOP;
         ex_dest_q   <= 3'd0;
         ex_reg_we_q <= 1'b0;
         ex_a_q      <= '0;
         ex_b_q      <= '0;
         ex_smdr_q   <= '0;
         ex_val2_q   <= 4'd0;
         ex_val3_q   <= 4'd0;
         halted_q    <= 1'b0;
      end else if (issue) begin
         ex_valid_q  <= 1'b1;
         ex_opcode_q <= opcode;
         ex_dest_q   <= r1;
         ex_reg_we_q <= reg_we;
         ex_a_q      <= op_a;
         ex_b_q      <= op_b;
         ex_smdr_q   <= smdr;
         ex_val2_q   <= id_ir_q[7:4];
         ex_val3_q   <= id_ir_q[3:0];
         if (opcode == OP_HALT) halted_q <= 1'b1;
      end else begin
         ex_valid_q  <= 1'b0;
         ex_opcode_q <= OP_NOP;
         ex_dest_q   <= 3'd0;
         ex_reg_we_q <= 1'b0;
         ex_a_q      <= '0;
         ex_b_q      <= '0;
         ex_smdr_q   <= '0;
         ex_val2_q   <= 4'd0;
         ex_val3_q   <= 4'd0;
      end
   end

   assign ex_valid  = ex_valid_q;
   assign ex_opcode = ex_opcode_q;
   assign ex_dest   = ex_dest_q;
   assign ex_reg_we = ex_reg_we_q;
   assign ex_a      = ex_a_q;
   assign ex_b      = ex_b_q;
   assign ex_smdr   = ex_smdr_q;
   assign ex_val2   = ex_val2_q;
   assign ex_val3   = ex_val3_q;
   assign halted    = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_id_stage_param.sv
// ============================================================================
// tb_id_stage_param : directed scoreboard bench for id_stage_param
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_id_stage_param;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        if_valid = 1'b0;
   logic [15:0] if_instr = 16'h0000;
   logic        flush = 1'b0;
   logic        wb_we = 1'b0;
   logic [2:0]  wb_addr = 3'd0;
   logic [31:0] wb_data = 32'd0;

   logic        stall, ex_valid, ex_reg_we, halted;
   logic [4:0]  ex_opcode;
   logic [2:0]  ex_dest;
   logic [15:0] ex_a, ex_b, ex_smdr;
   logic [3:0]  ex_val2, ex_val3;

   logic        s_stall, s_ex_valid, s_ex_reg_we, s_halted;
   logic [4:0]  s_ex_opcode;
   logic [2:0]  s_ex_dest;
   logic [31:0] s_ex_a, s_ex_b, s_ex_smdr;
   logic [3:0]  s_ex_val2, s_ex_val3;

   logic        z_stall, z_ex_valid, z_ex_reg_we, z_halted;
   logic [4:0]  z_ex_opcode;
   logic [2:0]  z_ex_dest;
   logic [31:0] z_ex_a, z_ex_b, z_ex_smdr;
   logic [3:0]  z_ex_val2, z_ex_val3;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [4:0]  op;
      logic [2:0]  dest;
      logic        we;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] smdr;
      logic [3:0]  val2;
      logic [3:0]  val3;
   } exp_t;

   exp_t sb[$];

   id_stage_param u_dut (
      .clock(clock), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
      .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data[15:0]),
      .stall(stall), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_dest(ex_dest),
      .ex_reg_we(ex_reg_we), .ex_a(ex_a), .ex_b(ex_b), .ex_smdr(ex_smdr),
      .ex_val2(ex_val2), .ex_val3(ex_val3), .halted(halted)
   );

   id_stage_param #(.DATA_W(32), .BR_SEXT(1'b1)) u_dut_s (
      .clock(clock), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
      .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .stall(s_stall), .ex_valid(s_ex_valid), .ex_opcode(s_ex_opcode), .ex_dest(s_ex_dest),
      .ex_reg_we(s_ex_reg_we), .ex_a(s_ex_a), .ex_b(s_ex_b), .ex_smdr(s_ex_smdr),
      .ex_val2(s_ex_val2), .ex_val3(s_ex_val3), .halted(s_halted)
   );

   id_stage_param #(.DATA_W(32), .BR_SEXT(1'b0)) u_dut_z (
      .clock(clock), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
      .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .stall(z_stall), .ex_valid(z_ex_valid), .ex_opcode(z_ex_opcode), .ex_dest(z_ex_dest),
      .ex_reg_we(z_ex_reg_we), .ex_a(z_ex_a), .ex_b(z_ex_b), .ex_smdr(z_ex_smdr),
      .ex_val2(z_ex_val2), .ex_val3(z_ex_val3), .halted(z_halted)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [15:0] ins, input logic we,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] sm);
      exp_t e;
      e.op   = ins[15:11];
      e.dest = ins[10:8];
      e.we   = we;
      e.a    = a;
      e.b    = b;
      e.smdr = sm;
      e.val2 = ins[7:4];
      e.val3 = ins[3:0];
      sb.push_back(e);
   endtask

   // One clock; every valid ex_* beat is matched against the oldest expectation
   task automatic step();
      exp_t e;
      @(posedge clock);
      #1;
      if (ex_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_issue", 32'(ex_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("sb_opcode", 32'(ex_opcode), 32'(e.op));
            chk("sb_dest",   32'(ex_dest),   32'(e.dest));
            chk("sb_reg_we", 32'(ex_reg_we), 32'(e.we));
            chk("sb_a",      32'(ex_a),      32'(e.a));
            chk("sb_b",      32'(ex_b),      32'(e.b));
            chk("sb_smdr",   32'(ex_smdr),   32'(e.smdr));
            chk("sb_val2",   32'(ex_val2),   32'(e.val2));
            chk("sb_val3",   32'(ex_val3),   32'(e.val3));
         end
      end
   endtask

   task automatic wb(input logic [2:0] addr, input logic [31:0] data);
      wb_we   = 1'b1;
      wb_addr = addr;
      wb_data = data;
      step();
      wb_we   = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clock);
      #1;
      chk("rst_ex_valid",  32'(ex_valid),  32'd0);
      chk("rst_ex_opcode", 32'(ex_opcode), 32'd0);
      chk("rst_halted",    32'(halted),    32'd0);
      chk("rst_stall",     32'(stall),     32'd0);
      chk("rst_ex_a",      32'(ex_a),      32'd0);
      reset = 1'b1;

      // ADD r1,r2,r3 with preloaded operands
      wb(3'd2, 32'd5);
      wb(3'd3, 32'd7);
      if_valid = 1'b1; if_instr = 16'h2123;
      push(16'h2123, 1'b1, 16'd5, 16'd7, 16'd0);
      step();
      if_valid = 1'b0;
      step();
      chk("add_latency_issued", 32'(sb.size()), 32'd0);

      // LOAD r2,(r0+4) then ADD r3,r2,r1: one stall cycle, one bubble
      if_valid = 1'b1; if_instr = 16'h1204;
      push(16'h1204, 1'b1, 16'd0, 16'd4, 16'd0);
      step();
      if_instr = 16'h2321;
      push(16'h2321, 1'b1, 16'd5, 16'd0, 16'd0);
      step();
      chk("lu_stall_high", 32'(stall), 32'd1);
      step();
      chk("lu_bubble", 32'(ex_valid), 32'd0);
      chk("lu_stall_low", 32'(stall), 32'd0);
      if_valid = 1'b0;
      step();
      chk("lu_add_issued", 32'(sb.size()), 32'd0);

      // BZ r1,#F0: extension depends on BR_SEXT
      wb(3'd1, 32'h11);
      if_valid = 1'b1; if_instr = 16'h61F0;
      push(16'h61F0, 1'b0, 16'h0011, 16'h00F0, 16'd0);
      step();
      if_valid = 1'b0;
      step();
      chk("bz_sext32_b", s_ex_b, 32'hFFFF_FFF0);
      chk("bz_zext32_b", z_ex_b, 32'h0000_00F0);
      chk("bz_sext32_a", s_ex_a, 32'h0000_0011);

      // STORE r5,(r2+3) with simultaneous writeback of gr2 (bypass)
      wb(3'd5, 32'hBEEF);
      if_valid = 1'b1; if_instr = 16'h1D23;
      step();
      if_valid = 1'b0;
      wb_we = 1'b1; wb_addr = 3'd2; wb_data = 32'd9;
      push(16'h1D23, 1'b0, 16'd9, 16'd3, 16'hBEEF);
      step();
      wb_we = 1'b0;
      chk("st_issued", 32'(sb.size()), 32'd0);

      // flush in the cycle a load-use stall would occur
      if_valid = 1'b1; if_instr = 16'h1204;
      push(16'h1204, 1'b1, 16'd0, 16'd4, 16'd0);
      step();
      if_instr = 16'h2321;
      step();
      chk("fl_stall_pre", 32'(stall), 32'd1);
      flush = 1'b1;
      if_valid = 1'b0;
      #1;
      chk("fl_stall_masked", 32'(stall), 32'd0);
      step();
      flush = 1'b0;
      chk("fl_bubble", 32'(ex_valid), 32'd0);
      step();
      chk("fl_id_killed", 32'(ex_valid), 32'd0);

      // HALT then more instructions
      if_valid = 1'b1; if_instr = 16'h0800;
      push(16'h0800, 1'b0, 16'd0, 16'd0, 16'd0);
      step();
      if_instr = 16'h2123;
      step();
      chk("halt_set", 32'(halted), 32'd1);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("halt_bubble", 32'(ex_valid), 32'd0);
      end
      reset = 1'b0;
      #1;
      chk("mid_rst_halted", 32'(halted),    32'd0);
      chk("mid_rst_opcode", 32'(ex_opcode), 32'd0);
      chk("mid_rst_stall",  32'(stall),     32'd0);
      reset = 1'b1;

      // register file cleared by reset; then reset while ex_* is live
      if_valid = 1'b1; if_instr = 16'h2123;
      push(16'h2123, 1'b1, 16'd0, 16'd0, 16'd0);
      step();
      if_valid = 1'b0;
      step();
      chk("post_rst_issue", 32'(ex_valid), 32'd1);
      reset = 1'b0;
      #1;
      chk("live_rst_valid", 32'(ex_valid),  32'd0);
      chk("live_rst_dest",  32'(ex_dest),   32'd0);
      chk("live_rst_we",    32'(ex_reg_we), 32'd0);
      reset = 1'b1;

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
